// File: rtl/apb_servo_pwm_array_if.sv
// ---------------------------------------------------------------------------
// apb_servo_pwm_array_if
// APB3 bus bundle between the fabric master and the servo PWM array slave.
//   PSEL, PENABLE, PWRITE : transfer control (master -> slave)
//   PADDR, PWDATA         : byte address and write data (master -> slave)
//   PRDATA                : read data (slave -> master)
//   PREADY, PSLVERR       : completion and error response (slave -> master)
// ---------------------------------------------------------------------------
interface apb_servo_pwm_array_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                    input  PRDATA, PREADY, PSLVERR);
    modport slave  (input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                    output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_servo_pwm_array.sv
// ---------------------------------------------------------------------------
// apb_servo_pwm_array
// APB3 slave driving NUM_CH hobby-servo PWM outputs from one shared,
// programmable frame period. Each channel's applied pulse width (CURRENT)
// slews toward its target by at most STEP once per frame.
//   PCLK    : system clock
//   PRESERN : asynchronous active-low reset
//   apb     : APB3 slave port (PSEL/PENABLE/PWRITE/PADDR/PWDATA in,
//             PRDATA/PREADY/PSLVERR out)
//   HOLD    : asynchronous freeze request, synchronised here (2 flops)
//   pwm_out : registered PWM outputs, one per channel
// ---------------------------------------------------------------------------
module apb_servo_pwm_array #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CNT_WIDTH  = 21,
    parameter int unsigned PERIOD_RST = 2000000,
    parameter int unsigned PULSE_RST  = 150000,
    parameter int unsigned PULSE_MIN  = 100000,
    parameter int unsigned PULSE_MAX  = 200000
) (
    input  logic                 PCLK,
    input  logic                 PRESERN,
    apb_servo_pwm_array_if.slave apb,
    input  logic                 HOLD,
    output logic [NUM_CH-1:0]    pwm_out
);
    typedef logic [CNT_WIDTH-1:0] cnt_t;

    localparam cnt_t        ONE   = cnt_t'(1);
    localparam cnt_t        TWO   = cnt_t'(2);
    localparam logic [31:0] MIN32 = 32'(PULSE_MIN);
    localparam logic [31:0] MAX32 = 32'(PULSE_MAX);

    // Targets are clamped on the full 32-bit bus value so large writes saturate.
    function automatic cnt_t clamp_pulse(input logic [31:0] v);
        if (v < MIN32)      return cnt_t'(MIN32);
        else if (v > MAX32) return cnt_t'(MAX32);
        else                return cnt_t'(v);
    endfunction

    function automatic cnt_t clamp_period(input logic [31:0] v);
        cnt_t t;
        t = cnt_t'(v);
        return (t < TWO) ? TWO : t;
    endfunction

    // One frame's slew step; never overshoots, so no wrap can occur.
    function automatic cnt_t slew(input cnt_t cur, input cnt_t tgt, input cnt_t step);
        if (step == '0)   return tgt;
        if (tgt > cur)    return ((tgt - cur) <= step) ? tgt : cur + step;
        if (cur > tgt)    return ((cur - tgt) <= step) ? tgt : cur - step;
        return cur;
    endfunction

    logic              ctrl_gen_q, ctrl_gen_d;
    logic [NUM_CH-1:0] ctrl_en_q, ctrl_en_d;
    cnt_t              period_sh_q, period_sh_d;
    cnt_t              period_act_q, period_act_d;
    cnt_t              step_q, step_d;
    cnt_t              cnt_q, cnt_d;
    cnt_t              target_q [NUM_CH];
    cnt_t              target_d [NUM_CH];
    cnt_t              current_q [NUM_CH];
    cnt_t              current_d [NUM_CH];
    logic [NUM_CH-1:0] pwm_q, pwm_d;
    logic              hold_s1_q, hold_s2_q;

    logic [5:0]        idx;
    logic              wr_en, rd_en, wr_ok, frame_start;
    logic [31:0]       rdata;
    logic [NUM_CH-1:0] settled;
    logic              unused_addr;

    assign idx         = apb.PADDR[7:2];
    assign unused_addr = ^{apb.PADDR[31:8], apb.PADDR[1:0]};
    assign wr_en       = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign rd_en       = apb.PSEL & apb.PENABLE & ~apb.PWRITE;
    // Frames only exist while the generator runs; a stopped counter parked at
    // 0 must not keep slewing CURRENT every cycle.
    assign frame_start = ctrl_gen_q && (cnt_q == '0);

    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = wr_en & ~wr_ok;
    assign apb.PRDATA  = rd_en ? rdata : '0;
    assign pwm_out     = pwm_q;

    // Address decode: read mux plus "writable offset" flag.
    always_comb begin
        rdata = '0;
        wr_ok = 1'b0;
        for (int i = 0; i < NUM_CH; i++) settled[i] = (current_q[i] == target_q[i]);
        case (idx)
            6'd0: begin
                rdata[0]           = ctrl_gen_q;
                rdata[8 +: NUM_CH] = ctrl_en_q;
                wr_ok              = 1'b1;
            end
            6'd1: begin rdata = 32'(period_sh_q); wr_ok = 1'b1; end
            6'd2: begin rdata = 32'(step_q);      wr_ok = 1'b1; end
            6'd3: begin
                rdata[NUM_CH-1:0] = settled;
                rdata[31]         = hold_s2_q;
            end
            default: ;
        endcase
        for (int i = 0; i < NUM_CH; i++) begin
            if (idx == 6'(4 + i)) begin
                rdata = 32'(target_q[i]);
                wr_ok = 1'b1;
            end
            if (idx == 6'(12 + i)) rdata = 32'(current_q[i]);
        end
    end

    // Next state: frame counter, per-frame slew, output compare, bus writes.
    // Slew and period load read the old TARGET/shadow, so a same-cycle write
    // only takes effect from the following frame.
    always_comb begin
        ctrl_gen_d   = ctrl_gen_q;
        ctrl_en_d    = ctrl_en_q;
        period_sh_d  = period_sh_q;
        period_act_d = period_act_q;
        step_d       = step_q;
        target_d     = target_q;
        current_d    = current_q;

        if (!ctrl_gen_q)                        cnt_d = '0;
        else if (cnt_q >= period_act_q - ONE)   cnt_d = '0;
        else                                    cnt_d = cnt_q + ONE;

        for (int i = 0; i < NUM_CH; i++)
            pwm_d[i] = ctrl_gen_q & ctrl_en_q[i] & (cnt_q < current_q[i]);

        if (frame_start) begin
            period_act_d = period_sh_q;
            if (!hold_s2_q) begin
                for (int i = 0; i < NUM_CH; i++)
                    current_d[i] = slew(current_q[i], target_q[i], step_q);
            end
        end

        if (wr_en && wr_ok) begin
            case (idx)
                6'd0: begin
                    ctrl_gen_d = apb.PWDATA[0];
                    ctrl_en_d  = apb.PWDATA[8 +: NUM_CH];
                end
                6'd1:    period_sh_d = clamp_period(apb.PWDATA);
                6'd2:    step_d      = cnt_t'(apb.PWDATA);
                default: ;
            endcase
            for (int i = 0; i < NUM_CH; i++)
                if (idx == 6'(4 + i)) target_d[i] = clamp_pulse(apb.PWDATA);
        end
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            ctrl_gen_q   <= 1'b0;
            ctrl_en_q    <= '0;
            period_sh_q  <= cnt_t'(PERIOD_RST);
            period_act_q <= cnt_t'(PERIOD_RST);
            step_q       <= '0;
            cnt_q        <= '0;
            pwm_q        <= '0;
            hold_s1_q    <= 1'b0;
            hold_s2_q    <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                target_q[i]  <= cnt_t'(PULSE_RST);
                current_q[i] <= cnt_t'(PULSE_RST);
            end
        end else begin
            ctrl_gen_q   <= ctrl_gen_d;
            ctrl_en_q    <= ctrl_en_d;
            period_sh_q  <= period_sh_d;
            period_act_q <= period_act_d;
            step_q       <= step_d;
            cnt_q        <= cnt_d;
            pwm_q        <= pwm_d;
            hold_s1_q    <= HOLD;
            hold_s2_q    <= hold_s1_q;
            target_q     <= target_d;
            current_q    <= current_d;
        end
    end
endmodule
